tdm_demux: RTL and testbench
============================

# tdm_demux

Time-division demultiplexer: the receive end of the serial channel-mux path. It accepts a single-bit time-multiplexed stream, framed by a sync pulse, and distributes each time slot into its own parallel channel word. Completed frames are published atomically with a one-cycle strobe. It detects framing loss and re-acquires framing.

## Interface
Parameters:
- NCH, 4, number of time slots (channels) per frame; ≥2
- W, 8, bits per slot; ≥2

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- din  input  1  serial data bit, MSB of each slot first
- fsync  input  1  frame sync; high with the first bit (slot 0, MSB) of a frame
- en  input  1  bit strobe; din/fsync sampled only when en=1
- ch_data  output  NCH*W  published channel words; slot k at bits [k*W+W-1 : k*W]
- frame_valid  output  1  one-cycle pulse: ch_data just updated with a complete frame
- sync_err  output  1  one-cycle pulse: framing violation detected
- locked  output  1  high while in RECV state
- slot_idx  output  clog2(NCH)  slot currently being received (0 in HUNT)

## Operation
- Internal state: FSM {HUNT, RECV}; bit counter bcnt (0..W-1); slot counter scnt (0..NCH-1); W-bit shift register; NCH*W shadow buffer.
- Sample cycle = rising edge with en=1. Non-sample cycles change nothing except clearing the pulse outputs.
- Shift: sr <= {sr[W-2:0], din} (MSB first).
- HUNT:
  - Sample with fsync=1: din shifted in as bit 0 of slot 0; bcnt=1, scnt=0; go RECV.
  - Sample with fsync=0: ignored.
- RECV, sample at position (scnt, bcnt):
  - Expected frame start (scnt=0, bcnt=0) with fsync=1: normal; shift, bcnt=1.
  - Expected frame start with fsync=0: sync_err pulse; bit discarded; go HUNT; counters to 0.
  - fsync=1 at any other position: sync_err pulse; partial frame discarded (shadow not published). Bit taken as slot 0 bit 0; bcnt=1, scnt=0; stay RECV.
  - Otherwise: shift. On bcnt=W-1, the completed word {sr[W-2:0],din} is written to shadow slot scnt, bcnt wraps to 0 and scnt increments.
  - Last bit of last slot (scnt=NCH-1, bcnt=W-1): slot NCH-1 written. The whole shadow (including this word) is copied to ch_data and frame_valid pulses. scnt wraps to 0.
- ch_data holds its value between frames. It is never partially updated.
- slot_idx = scnt.
- locked = (state==RECV).

## Timing
- Reset values (asynchronous, while rst_n=0): ch_data=0, shadow=0, sr=0, frame_valid=0, sync_err=0, locked=0, slot_idx=0, state=HUNT, counters 0.
- Latency: ch_data and frame_valid update on the same edge that samples the frame's final bit. They are visible the cycle after, and frame_valid stays high for exactly one clk.
- sync_err is high for exactly one clk, on the edge that samples the offending bit.
- frame_valid and sync_err are never high together.
- Throughput: one bit per clk with en held high. No minimum gap is required between frames.
- en=0 on a last-bit cycle delays publication until that bit is actually sampled.
- Reset asserted mid-frame: partial data lost; ch_data returns to 0. After release, the block waits in HUNT for the next fsync.
- fsync while en=0 is ignored.

## Test plan
- Reset then clean frame (NCH=4, W=8): stream slots 0xA5,0x3C,0xFF,0x01 with en=1 continuously and fsync on the first bit. Required: frame_valid exactly once, one cycle after bit 32; ch_data=0x01FF3CA5; locked=1 from the first bit; sync_err never asserted.
- Back-to-back frames: frame of 0x11,0x22,0x33,0x44, then 0x55,0x66,0x77,0x88 with no gap. Required: two frame_valid pulses 32 cycles apart; ch_data first 0x44332211, then 0x88776655.
- en gating: the same frame with en=0 on every other clk, din toggling randomly on en=0 cycles. Required: identical ch_data; frame_valid after the 64th clk edge.
- Early fsync: fsync asserted at slot 2 bit 3. Required: sync_err pulse on that sample; no frame_valid; the prior ch_data is held. A full frame then follows from that bit: frame_valid after 32 more samples, with the new data.
- Missing fsync: after a good frame, the next frame-start bit arrives with fsync=0. Required: sync_err pulse; locked drops the next cycle; bits are ignored until fsync; re-lock then yields a correct frame.
- Async reset mid-frame: pull rst_n low at slot 1 bit 5, with no clk edge needed. Required: all outputs 0 immediately; after release, no activity until fsync.

Source files
------------

// File: rtl/tdm_if.sv
// Serial TDM receive bundle: bit stream, framing and strobe in; published frame and status out.
interface tdm_if #(
    parameter int NCH = 4,
    parameter int W   = 8
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic              din;
    logic              fsync;
    logic              en;
    logic [NCH*W-1:0]  ch_data;
    logic              frame_valid;
    logic              sync_err;
    logic              locked;
    logic [SW-1:0]     slot_idx;

    modport master (
        output din, fsync, en,
        input  ch_data, frame_valid, sync_err, locked, slot_idx
    );

    modport slave (
        input  din, fsync, en,
        output ch_data, frame_valid, sync_err, locked, slot_idx
    );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: splits a framed single-bit stream into NCH parallel W-bit words,
// publishing whole frames atomically and re-acquiring framing after a sync violation.
module tdm_demux #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    tdm_if.slave bus
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] BLAST = CW'(W - 1);
    localparam logic [SW-1:0] SLAST = SW'(NCH - 1);

    typedef enum logic {HUNT, RECV} state_t;

    state_t            state;
    logic [CW-1:0]     bcnt;
    logic [SW-1:0]     scnt;
    // Only the low W-1 bits of the shift register are ever consumed; the incoming bit completes the word.
    logic [W-2:0]      sr;
    logic [NCH*W-1:0]  shadow;
    logic [NCH*W-1:0]  shadow_nxt;
    logic [NCH*W-1:0]  ch_data;
    logic              frame_valid;
    logic              sync_err;
    logic [W-1:0]      word;
    logic              frame_start;

    assign word        = {sr, bus.din};
    assign frame_start = (scnt == '0) && (bcnt == '0);

    always_comb begin
        shadow_nxt = shadow;
        for (int k = 0; k < NCH; k++) begin
            if (scnt == SW'(k)) begin
                shadow_nxt[k*W +: W] = word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            bcnt        <= '0;
            scnt        <= '0;
            sr          <= '0;
            shadow      <= '0;
            ch_data     <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (bus.en) begin
                case (state)
                    HUNT: begin
                        if (bus.fsync) begin
                            sr    <= word[W-2:0];
                            bcnt  <= CW'(1);
                            scnt  <= '0;
                            state <= RECV;
                        end
                    end
                    RECV: begin
                        if (frame_start && !bus.fsync) begin
                            // Lost framing: drop the bit and wait for the next sync.
                            sync_err <= 1'b1;
                            state    <= HUNT;
                            bcnt     <= '0;
                            scnt     <= '0;
                        end else if (!frame_start && bus.fsync) begin
                            // Early sync restarts the frame on this bit; the partial frame is never published.
                            sync_err <= 1'b1;
                            sr       <= word[W-2:0];
                            bcnt     <= CW'(1);
                            scnt     <= '0;
                        end else begin
                            sr <= word[W-2:0];
                            if (bcnt == BLAST) begin
                                shadow <= shadow_nxt;
                                bcnt   <= '0;
                                if (scnt == SLAST) begin
                                    ch_data     <= shadow_nxt;
                                    frame_valid <= 1'b1;
                                    scnt        <= '0;
                                end else begin
                                    scnt <= scnt + 1'b1;
                                end
                            end else begin
                                bcnt <= bcnt + 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.ch_data     = ch_data;
    assign bus.frame_valid = frame_valid;
    assign bus.sync_err    = sync_err;
    assign bus.locked      = (state == RECV);
    assign bus.slot_idx    = scnt;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (NCH=4, W=8): table of clean frames plus framing-fault and reset sequences.
module tb_tdm_demux;
    logic clk;
    logic rst_n;
    int   nchecks;
    int   nerrors;
    int   both_high;

    tdm_if #(.NCH(4), .W(8)) bus ();

    tdm_demux #(.NCH(4), .W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  s0;
        logic [7:0]  s1;
        logic [7:0]  s2;
        logic [7:0]  s3;
        bit          gap;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic d, input logic fs, input logic e);
        bus.din   = d;
        bus.fsync = fs;
        bus.en    = e;
        @(posedge clk);
        #1;
        if (bus.frame_valid && bus.sync_err) both_high++;
    endtask

    task automatic send_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3, input bit gap, input logic [31:0] exp,
                              input logic [31:0] prev, input bit err_first);
        logic [31:0] w;
        int edges, fv_at, fvn, sen, slot_bad, k, b;
        w = {s3, s2, s1, s0};
        edges = 0; fv_at = -1; fvn = 0; sen = 0; slot_bad = 0;
        for (int i = 0; i < 32; i++) begin
            k = i / 8;
            b = 7 - (i % 8);
            if (gap) begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                edges++;
                if (bus.frame_valid) fvn++;
                if (bus.sync_err) sen++;
            end
            drive(w[k*8+b], (i == 0), 1'b1);
            edges++;
            if (bus.frame_valid) begin fvn++; fv_at = edges; end
            if (bus.sync_err) sen++;
            if (i == 0) begin
                chk("sync_err_first_bit", 64'(bus.sync_err), 64'(err_first));
                chk("locked_first_bit", 64'(bus.locked), 64'd1);
                chk("fv_clear_first_bit", 64'(bus.frame_valid), 64'd0);
            end
            if (i == 30) chk("ch_data_held", 64'(bus.ch_data), 64'(prev));
            if (i < 31 && bus.slot_idx != 2'((i + 1) / 8)) slot_bad++;
        end
        chk("fv_edge", 64'(fv_at), gap ? 64'd64 : 64'd32);
        chk("fv_count", 64'(fvn), 64'd1);
        chk("sync_err_count", 64'(sen), 64'(err_first));
        chk("ch_data", 64'(bus.ch_data), 64'(exp));
        chk("slot_idx_track", 64'(slot_bad), 64'd0);
    endtask

    initial begin
        logic [31:0] prev;
        int cnt_fv, cnt_se, cnt_lk;
        nchecks = 0; nerrors = 0; both_high = 0;
        vecs[0] = '{8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0, 32'h01FF3CA5};
        vecs[1] = '{8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 32'h44332211};
        vecs[2] = '{8'h55, 8'h66, 8'h77, 8'h88, 1'b0, 32'h88776655};
        vecs[3] = '{8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b1, 32'h01FF3CA5};

        rst_n = 1'b0; bus.din = 1'b0; bus.fsync = 1'b0; bus.en = 1'b0;
        #12;
        chk("rst_ch_data", 64'(bus.ch_data), 64'd0);
        chk("rst_fv", 64'(bus.frame_valid), 64'd0);
        chk("rst_sync_err", 64'(bus.sync_err), 64'd0);
        chk("rst_locked", 64'(bus.locked), 64'd0);
        chk("rst_slot_idx", 64'(bus.slot_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // HUNT ignores data without fsync
        cnt_lk = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b1);
            if (bus.locked) cnt_lk++;
        end
        chk("hunt_idle_locked", 64'(cnt_lk), 64'd0);

        prev = 32'h0;
        for (int i = 0; i < 4; i++) begin
            send_frame(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].gap, vecs[i].exp, prev, 1'b0);
            prev = vecs[i].exp;
        end

        // Early fsync at slot 2 bit 3
        cnt_fv = 0; cnt_se = 0;
        for (int i = 0; i < 19; i++) begin
            drive(1'(i % 3), (i == 0), 1'b1);
            if (bus.frame_valid) cnt_fv++;
            if (bus.sync_err) cnt_se++;
        end
        chk("early_partial_fv", 64'(cnt_fv), 64'd0);
        chk("early_partial_se", 64'(cnt_se), 64'd0);
        chk("early_partial_slot", 64'(bus.slot_idx), 64'd2);
        send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0, 32'hEFBEADDE, prev, 1'b1);
        prev = 32'hEFBEADDE;

        // Missing fsync at the expected frame start
        drive(1'b1, 1'b0, 1'b1);
        chk("missing_sync_err", 64'(bus.sync_err), 64'd1);
        chk("missing_locked", 64'(bus.locked), 64'd0);
        chk("missing_fv", 64'(bus.frame_valid), 64'd0);
        cnt_lk = 0; cnt_se = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b1);
            if (bus.locked) cnt_lk++;
            if (bus.sync_err) cnt_se++;
        end
        chk("hunt_after_loss_locked", 64'(cnt_lk), 64'd0);
        chk("hunt_after_loss_se", 64'(cnt_se), 64'd0);
        chk("hunt_after_loss_data", 64'(bus.ch_data), 64'(prev));
        send_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 32'h78563412, prev, 1'b0);

        // Asynchronous reset at slot 1 bit 5
        for (int i = 0; i < 13; i++) drive(1'(i % 2), (i == 0), 1'b1);
        chk("pre_rst_slot", 64'(bus.slot_idx), 64'd1);
        chk("pre_rst_locked", 64'(bus.locked), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ch_data", 64'(bus.ch_data), 64'd0);
        chk("async_rst_locked", 64'(bus.locked), 64'd0);
        chk("async_rst_slot", 64'(bus.slot_idx), 64'd0);
        chk("async_rst_fv", 64'(bus.frame_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_lk = 0; cnt_fv = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b1);
            if (bus.locked) cnt_lk++;
            if (bus.frame_valid) cnt_fv++;
        end
        chk("post_rst_locked", 64'(cnt_lk), 64'd0);
        chk("post_rst_fv", 64'(cnt_fv), 64'd0);
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0, 32'h01FF3CA5, 32'h0, 1'b0);

        chk("fv_and_sync_err_exclusive", 64'(both_high), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
